// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Turns a load or store request from the control path into one transaction
// on a simple valid/ready memory request bus. Stores go out as a masked,
// lane-aligned write. Loads wait for a single response beat, then the
// addressed bytes are extracted and sign- or zero-extended. Illegal or
// misaligned accesses complete straight away with fault set and never reach
// the bus.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle request, sampled only while idle
//   mem_read, mem_write access direction (exactly one must be set)
//   funct3              access size / signedness (instruction[14:12])
//   addr, store_data    effective address and store value (rs2)
//   busy                high while a transaction is in flight
//   done, fault         completion pulse; fault is meaningful with done
//   load_data           extended load result, held until the next start
//   mem_req_*           request channel (valid/ready handshake)
//   mem_rsp_*           load response channel (no back-pressure)
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int N = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           mem_read,
    input  logic           mem_write,
    input  logic [2:0]     funct3,
    input  logic [N-1:0]   addr,
    input  logic [N-1:0]   store_data,
    output logic           busy,
    output logic           done,
    output logic           fault,
    output logic [N-1:0]   load_data,
    output logic           mem_req_valid,
    input  logic           mem_req_ready,
    output logic           mem_req_we,
    output logic [N-1:0]   mem_req_addr,
    output logic [N-1:0]   mem_req_wdata,
    output logic [N/8-1:0] mem_req_wstrb,
    input  logic           mem_rsp_valid,
    input  logic [N-1:0]   mem_rsp_rdata
);

    localparam int NB = N / 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic           we_q;
    logic           fault_q;
    logic [2:0]     funct3_q;
    logic [2:0]     byteOff_q;
    logic [N-1:0]   reqAddr_q;
    logic [N-1:0]   wdata_q;
    logic [NB-1:0]  wstrb_q;
    logic [N-1:0]   loadData_q;

    logic           accept;
    logic           misaligned;
    logic           illegal;
    logic [NB-1:0]  sizeMask;
    logic [N-1:0]   rspShifted;
    logic [N-1:0]   loadExt;

    assign accept = (state_q == IDLE) && start;

    // Legality of the incoming request. funct3[1:0] encodes the access size
    // for both loads and stores, so alignment is checked the same way for
    // either direction.
    always_comb begin
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = |addr[1:0];
            2'b11:   misaligned = |addr[2:0];
            default: misaligned = 1'b0;
        endcase
        illegal = (mem_read == mem_write)
               || (mem_read && (funct3 == 3'b111))
               || (mem_write && funct3[2])
               || misaligned;
    end

    // Byte-enable pattern for a store of the requested size, before it is
    // moved into the addressed lanes.
    always_comb begin
        sizeMask = '0;
        case (funct3[1:0])
            2'b00:   sizeMask = NB'(8'h01);
            2'b01:   sizeMask = NB'(8'h03);
            2'b10:   sizeMask = NB'(8'h0F);
            default: sizeMask = NB'(8'hFF);
        endcase
    end

    // Load extraction: bring the addressed byte lane down to bit 0, then
    // extend according to the registered size/sign code.
    always_comb begin
        rspShifted = mem_rsp_rdata >> {byteOff_q, 3'b000};
        loadExt    = '0;
        case (funct3_q)
            3'b000:  loadExt = {{(N-8){rspShifted[7]}},   rspShifted[7:0]};
            3'b001:  loadExt = {{(N-16){rspShifted[15]}}, rspShifted[15:0]};
            3'b010:  loadExt = {{(N-32){rspShifted[31]}}, rspShifted[31:0]};
            3'b011:  loadExt = rspShifted;
            3'b100:  loadExt = {{(N-8){1'b0}},  rspShifted[7:0]};
            3'b101:  loadExt = {{(N-16){1'b0}}, rspShifted[15:0]};
            3'b110:  loadExt = {{(N-32){1'b0}}, rspShifted[31:0]};
            default: loadExt = '0;
        endcase
    end

    // Next-state logic. Faulted requests skip the bus entirely and go
    // straight to DONE so they complete one cycle after start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = illegal ? DONE : REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d = we_q ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and payload registers. The whole request payload is built at
    // accept time so it stays stable for as long as the bus stalls, and
    // load_data is cleared then so a faulted access reports zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            fault_q    <= 1'b0;
            funct3_q   <= '0;
            byteOff_q  <= '0;
            reqAddr_q  <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            loadData_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q       <= mem_write;
                fault_q    <= illegal;
                funct3_q   <= funct3;
                byteOff_q  <= addr[2:0];
                reqAddr_q  <= {addr[N-1:3], 3'b000};
                wdata_q    <= mem_write ? (store_data << {addr[2:0], 3'b000}) : '0;
                wstrb_q    <= mem_write ? (sizeMask << addr[2:0]) : '0;
                loadData_q <= '0;
            end
            if ((state_q == WAIT) && mem_rsp_valid) begin
                loadData_q <= loadExt;
            end
        end
    end

    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign fault         = (state_q == DONE) && fault_q;
    assign load_data     = loadData_q;
    assign mem_req_valid = (state_q == REQ);
    assign mem_req_we    = we_q;
    assign mem_req_addr  = reqAddr_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wstrb = wstrb_q;

endmodule
